subframe_ctrl: RTL and testbench
================================

SUBFRAME_CTRL -- requirements
Module: subframe_ctrl

Interface
REQ-001 The block SHALL have parameter IMAGE_HEIGHT, default 200, meaning 32-bit words per image column, padding included.
REQ-002 The block SHALL have parameter IMAGE_WIDTH, default 200, meaning image columns delivered on the input stream.
REQ-003 The block SHALL have parameter KERNEL_WIDTH, default 3, meaning convolution kernel width in columns.
REQ-004 The block SHALL have parameter NB_DATA, default 32, meaning stream and datapath word width (4 pixels of 8 bits).
REQ-005 The block SHALL have port i_clk  in  1  clock; all logic on the rising edge.
REQ-006 The block SHALL have port i_reset  in  1  reset; synchronous, active-high.
REQ-007 The block SHALL have port i_start  in  1  frame start request, sampled only in IDLE.
REQ-008 The block SHALL have ports s_axis_tdata/tvalid/tready/tlast  in/in/out/in  NB_DATA/1/1/1  column-major pixel input stream.
REQ-009 The block SHALL have ports o_dp_data/o_dp_valid/o_dp_reset  out  NB_DATA/1/1  drive to the subframe convolution datapath.
REQ-010 The block SHALL have port i_dp_data  in  NB_DATA  datapath result, valid the cycle after o_dp_valid.
REQ-011 The block SHALL have ports m_axis_tdata/tvalid/tready/tlast  out/out/in/out  NB_DATA/1/1/1  convolved output stream.
REQ-012 The block SHALL have ports o_busy, o_done, o_err_tlast  out  1 each  status: not IDLE, 1-cycle frame-complete pulse, sticky tlast error.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, PAD_PRE, RUN, PAD_POST, DRAIN and DONE.
REQ-014 IDLE SHALL go to CLEAR on i_start; CLEAR SHALL last 1 cycle with o_dp_reset=1 and clear o_err_tlast and all counters.
REQ-015 CLEAR SHALL go to PAD_PRE if padding is enabled, else RUN; PAD_PRE SHALL go to RUN; RUN SHALL go to PAD_POST (padding enabled) or DRAIN; PAD_POST SHALL go to DRAIN; DRAIN SHALL go to DONE; DONE SHALL go to IDLE.
REQ-016 The row counter SHALL run 0..IMAGE_HEIGHT-1 and wrap into the column counter, which runs 0..TOTAL_COLS-1; TOTAL_COLS SHALL equal IMAGE_WIDTH, plus 2 when padding is enabled.
REQ-017 An issue SHALL be a cycle with o_dp_valid=1; it SHALL occur only when (out_fifo_count - pop + pend) < 2, where pend is a capture scheduled from the previous issue.
REQ-018 In RUN, s_axis_tready SHALL equal the issue condition; on tvalid&&tready, o_dp_data SHALL equal tdata in the same cycle.
REQ-019 An issue with col_cnt >= KERNEL_WIDTH-1 SHALL set pend; the next cycle SHALL push i_dp_data into a 2-entry output FIFO.
REQ-020 m_axis SHALL present the FIFO head; a pop SHALL occur on tvalid&&tready; FIFO order SHALL be preserved and there SHALL be no loss under any m_axis_tready pattern.
REQ-021 m_axis_tlast SHALL be 1 on output word number (TOTAL_COLS-KERNEL_WIDTH+1)*IMAGE_HEIGHT of the frame.
REQ-022 RUN SHALL exit after the word at row IMAGE_HEIGHT-1 of the last input column is issued.
REQ-023 DRAIN SHALL exit when pend=0 and the FIFO is empty; o_done SHALL be 1 in DONE only.
REQ-024 o_err_tlast SHALL be set if s_axis_tlast=1 on any word except the frame's last input word, or =0 on that word; the frame SHALL continue by count regardless.
REQ-025 i_start SHALL be ignored outside IDLE; s_axis_tready SHALL be 0 outside RUN.

Reset
REQ-026 On i_reset, state SHALL go to IDLE, counters, pend and the FIFO SHALL be cleared, and every output SHALL be 0 on the next cycle, including mid-frame.

Configuration
REQ-027 With SUBFRAME_CTRL_PAD_EN defined, PAD_PRE and PAD_POST SHALL each issue IMAGE_HEIGHT words of 0 subject to REQ-017, with s_axis_tready=0.
REQ-028 Without SUBFRAME_CTRL_PAD_EN, those states and their logic SHALL be absent and the input stream SHALL carry padding itself.

Structure
REQ-029 The state encoding, NB_PIXEL=8 and the output FIFO depth 2 SHALL be in shared package subframe_pkg.
REQ-030 The output FIFO SHALL be sub-module subframe_out_fifo; the counters and FSM SHALL stay in subframe_ctrl.

Verification (IMAGE_HEIGHT=4, IMAGE_WIDTH=5, KERNEL_WIDTH=3)
REQ-031 Reset asserted 3 cycles -> all outputs 0 and o_busy=0.
REQ-032 Macro off, 20 words, m_axis_tready=1 -> exactly 12 outputs equal to the i_dp_data model, tlast on the 12th, o_done pulses once, o_err_tlast=0.
REQ-033 m_axis_tready=0 for 10 cycles after the 3rd output -> s_axis_tready drops, FIFO count <=2, all 12 outputs delivered in order.
REQ-034 tlast on the 7th input word -> o_err_tlast=1 from the next cycle; 12 outputs and o_done still occur.
REQ-035 Macro on, 20 words -> 4 zero issues before and 4 after the input words on o_dp_data, 20 outputs, tlast on the 20th.
REQ-036 i_reset at the 9th input word, then i_start -> fresh frame produces 12 correct outputs.

Source files
------------

// File: rtl/subframe_pkg.sv
// Shared types and constants for the subframe convolution controller.
package subframe_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        PAD_PRE  = 3'd2,
        RUN      = 3'd3,
        PAD_POST = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int NB_PIXEL       = 8;
    localparam int OUT_FIFO_DEPTH = 2;
    localparam int OUT_FIFO_CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

    // Counter width helper that never collapses to zero bits.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subframe_out_fifo.sv
// Small output FIFO holding datapath results until the m_axis consumer accepts them.
module subframe_out_fifo
    import subframe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = OUT_FIFO_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = min_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/subframe_ctrl.sv
// Frame sequencer feeding a subframe convolution datapath and collecting its results.
// Optional column zero-padding is built in when SUBFRAME_CTRL_PAD_EN is defined.
module subframe_ctrl
    import subframe_pkg::*;
#(
    parameter int IMAGE_HEIGHT = 200,
    parameter int IMAGE_WIDTH  = 200,
    parameter int KERNEL_WIDTH = 3,
    parameter int NB_DATA      = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [NB_DATA-1:0] o_dp_data,
    output logic               o_dp_valid,
    output logic               o_dp_reset,
    input  logic [NB_DATA-1:0] i_dp_data,
    output logic [NB_DATA-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err_tlast
);
`ifdef SUBFRAME_CTRL_PAD_EN
    localparam int PAD_COLS = 2;
`else
    localparam int PAD_COLS = 0;
`endif
    localparam int TOTAL_COLS   = IMAGE_WIDTH + PAD_COLS;
    localparam int FIRST_IN_COL = PAD_COLS / 2;
    localparam int LAST_IN_COL  = FIRST_IN_COL + IMAGE_WIDTH - 1;
    localparam int OUT_WORDS    = (TOTAL_COLS - KERNEL_WIDTH + 1) * IMAGE_HEIGHT;
    localparam int ROW_W        = min_width(IMAGE_HEIGHT);
    localparam int COL_W        = min_width(TOTAL_COLS);
    localparam int OUT_W        = min_width(OUT_WORDS + 1);
    localparam int OCC_W        = OUT_FIFO_CNT_W + 1;

    state_t                      state_q;
    state_t                      state_d;
    logic [ROW_W-1:0]            row_q;
    logic [COL_W-1:0]            col_q;
    logic [OUT_W-1:0]            out_cnt_q;
    logic                        pend_q;
    logic                        err_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        dp_reset_q;

    logic [OUT_FIFO_CNT_W-1:0]   fifo_count;
    logic                        fifo_pop;
    logic                        fifo_clear;
    logic [OCC_W-1:0]            occupancy;
    logic                        can_issue;
    logic                        issue;
    logic                        in_hs;
    logic                        row_last;
    logic                        col_last;
    logic                        last_in_word;

    assign row_last     = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
    assign col_last     = (col_q == COL_W'(TOTAL_COLS - 1));
    assign last_in_word = row_last && (col_q == COL_W'(LAST_IN_COL));

    // A result slot is reserved at issue time so the FIFO can never overflow.
    assign fifo_pop   = m_axis_tvalid && m_axis_tready;
    assign occupancy  = {1'b0, fifo_count} - OCC_W'(fifo_pop) + OCC_W'(pend_q);
    assign can_issue  = (occupancy < OCC_W'(OUT_FIFO_DEPTH));
    assign fifo_clear = (state_q == CLEAR);

    assign s_axis_tready = (state_q == RUN) && can_issue;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign o_dp_data     = (state_q == RUN) ? s_axis_tdata : '0;
    assign o_dp_valid    = issue;

    always_comb begin
        issue = 1'b0;
        case (state_q)
            RUN:      issue = in_hs;
`ifdef SUBFRAME_CTRL_PAD_EN
            PAD_PRE,
            PAD_POST: issue = can_issue;
`endif
            default:  issue = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_start) state_d = CLEAR;
`ifdef SUBFRAME_CTRL_PAD_EN
            CLEAR:    state_d = PAD_PRE;
            PAD_PRE:  if (issue && row_last) state_d = RUN;
            RUN:      if (issue && last_in_word) state_d = PAD_POST;
            PAD_POST: if (issue && row_last && col_last) state_d = DRAIN;
`else
            CLEAR:    state_d = RUN;
            RUN:      if (issue && last_in_word) state_d = DRAIN;
`endif
            DRAIN:    if (!pend_q && (fifo_count == '0)) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            out_cnt_q  <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dp_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            dp_reset_q <= (state_d == CLEAR);
            // Only full kernel windows produce a result one cycle later.
            pend_q     <= issue && (col_q >= COL_W'(KERNEL_WIDTH - 1));
            if (state_q == CLEAR) begin
                row_q     <= '0;
                col_q     <= '0;
                out_cnt_q <= '0;
                err_q     <= 1'b0;
            end else begin
                if (issue) begin
                    if (row_last) begin
                        row_q <= '0;
                        col_q <= col_last ? '0 : col_q + COL_W'(1);
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                if (fifo_pop) begin
                    out_cnt_q <= out_cnt_q + OUT_W'(1);
                end
                if ((state_q == RUN) && in_hs && (s_axis_tlast != last_in_word)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    subframe_out_fifo #(
        .DATA_W (NB_DATA),
        .DEPTH  (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear_i (fifo_clear),
        .push_i  (pend_q),
        .data_i  (i_dp_data),
        .pop_i   (fifo_pop),
        .data_o  (m_axis_tdata),
        .valid_o (m_axis_tvalid),
        .count_o (fifo_count)
    );

    assign m_axis_tlast = m_axis_tvalid && (out_cnt_q == OUT_W'(OUT_WORDS - 1));
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_dp_reset   = dp_reset_q;
    assign o_err_tlast  = err_q;

endmodule

// File: tb/tb_subframe_ctrl.sv
// Scoreboard bench for subframe_ctrl with a registered datapath model on i_dp_data.
module tb_subframe_ctrl;
    localparam int H  = 4;
    localparam int W  = 5;
    localparam int K  = 3;
    localparam int NB = 32;
`ifdef SUBFRAME_CTRL_PAD_EN
    localparam int PADC = 2;
`else
    localparam int PADC = 0;
`endif
    localparam int NWORDS     = H * W;
    localparam int PRE_ISSUES = (PADC / 2) * H;
    localparam int EXP_OUT    = (W + PADC - K + 1) * H;
    localparam int EXP_ISSUES = NWORDS + PADC * H;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_start = 1'b0;
    logic [NB-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [NB-1:0] dp_data;
    logic          dp_valid;
    logic          dp_reset;
    logic [NB-1:0] dp_q = '0;
    logic [NB-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err_tlast;

    int checks = 0;
    int errors = 0;
    logic [NB-1:0] sb_q[$];
    logic [NB-1:0] issue_q[$];
    logic [NB-1:0] words[NWORDS];
    int   out_n = 0, tlast_n = 0, done_n = 0, max_cnt = 0;
    int   stall_cnt = 0, stall_after = -1, cyc = 0, err_sample_cyc = -1;
    bit   saw_low = 0;
    logic err_before = 1'b0, err_after = 1'b0;

    always #5 clk = ~clk;

    subframe_ctrl #(
        .IMAGE_HEIGHT (H),
        .IMAGE_WIDTH  (W),
        .KERNEL_WIDTH (K),
        .NB_DATA      (NB)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .o_dp_data     (dp_data),
        .o_dp_valid    (dp_valid),
        .o_dp_reset    (dp_reset),
        .i_dp_data     (dp_q),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err_tlast   (o_err_tlast)
    );

    function automatic logic [NB-1:0] dp_f(input logic [NB-1:0] x);
        return (x * 32'd3) ^ 32'h5A5A_00FF;
    endfunction

    // Datapath stand-in: result appears the cycle after each issue.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_valid) dp_q <= dp_f(dp_data);
    end

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        logic [NB-1:0] exp_w;
        if (dp_valid) issue_q.push_back(dp_data);
        if (o_done) done_n++;
        if (int'(dut.u_out_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_out_fifo.count_o);
        if (stall_cnt > 0 && s_valid && !s_ready) saw_low = 1;
        if (cyc == err_sample_cyc) err_after = o_err_tlast;
        if (s_valid && s_ready) begin
            checks++;
            if (dp_valid !== 1'b1 || dp_data !== s_data) begin
                errors++;
                $display("FAIL dp_passthru: o_dp_valid=%b o_dp_data=%h, required 1 and %h", dp_valid, dp_data, s_data);
            end
        end
        if (m_valid && m_ready) begin
            out_n++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: output %0d data=%h, scoreboard empty", out_n, m_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (m_data !== exp_w) begin
                    errors++;
                    $display("FAIL out_data: output %0d got %h, required %h", out_n, m_data, exp_w);
                end
            end
            checks++;
            if (m_last !== (out_n == EXP_OUT)) begin
                errors++;
                $display("FAIL out_tlast: output %0d tlast=%b, required %b", out_n, m_last, out_n == EXP_OUT);
            end
            if (m_last) tlast_n++;
            if (out_n == stall_after) stall_cnt = 10;
        end
    end

    task automatic frame_begin();
        sb_q.delete();
        issue_q.delete();
        out_n = 0; tlast_n = 0; done_n = 0; max_cnt = 0;
        saw_low = 0; stall_after = -1; err_sample_cyc = -1;
    endtask

    task automatic run_frame(input int err_idx, input int rst_idx, output bit timed_out);
        int budget;
        timed_out = 0;
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            if (i == rst_idx) begin
                s_valid = 1'b0;
                i_reset = 1'b1;
                @(posedge clk); #1;
                i_reset = 1'b0;
                return;
            end
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = (err_idx < 0) ? (i == NWORDS - 1) : (i == err_idx);
            budget  = 0;
            @(negedge clk);
            while (!s_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (!s_ready) begin
                checks++; errors++;
                $display("FAIL input_timeout: word %0d s_axis_tready=%b, required 1", i, s_ready);
                s_valid = 1'b0;
                timed_out = 1;
                return;
            end
            if (i == err_idx) begin
                err_before = o_err_tlast;
                err_sample_cyc = cyc + 1;
            end
            if (i / H + PADC / 2 >= K - 1) sb_q.push_back(dp_f(words[i]));
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int p = 0; p < PRE_ISSUES; p++) sb_q.push_back(dp_f('0));
        budget = 0;
        while (done_n == 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (done_n == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: o_done count=%0d, required 1", done_n);
            timed_out = 1;
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_err_tlast, dp_valid, dp_reset, s_ready, m_valid, m_last} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/err/dpv/dpr/srdy/mvld/mlast=%b, required 00000000",
                     {o_busy, o_done, o_err_tlast, dp_valid, dp_reset, s_ready, m_valid, m_last});
        end
        checks++;
        if (dp_data !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_data: o_dp_data=%h m_axis_tdata=%h, required 0 and 0", dp_data, m_data);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: o_busy=%b after release, required 0", o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to;
        logic [NB-1:0] exp_w;
        int idx;
        frame_begin();
        run_frame(-1, -1, to);
        checks++;
        if (out_n !== EXP_OUT) begin errors++; $display("FAIL basic_count: outputs=%0d, required %0d", out_n, EXP_OUT); end
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL basic_sb: %0d expected outputs missing, required 0", sb_q.size()); end
        checks++;
        if (tlast_n !== 1) begin errors++; $display("FAIL basic_tlast_n: tlast count=%0d, required 1", tlast_n); end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL basic_done: o_done pulses=%0d, required 1", done_n); end
        checks++;
        if (o_err_tlast !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: err=%b busy=%b, required 0 and 0", o_err_tlast, o_busy);
        end
        checks++;
        if (issue_q.size() !== EXP_ISSUES) begin
            errors++;
            $display("FAIL issue_count: issues=%0d, required %0d", issue_q.size(), EXP_ISSUES);
        end
        for (int i = 0; i < issue_q.size() && i < EXP_ISSUES; i++) begin
            idx = i - PRE_ISSUES;
            exp_w = (idx >= 0 && idx < NWORDS) ? words[idx] : '0;
            checks++;
            if (issue_q[i] !== exp_w) begin
                errors++;
                $display("FAIL issue_order: issue %0d o_dp_data=%h, required %h", i, issue_q[i], exp_w);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        frame_begin();
        stall_after = 3;
        run_frame(-1, -1, to);
        checks++;
        if (saw_low !== 1) begin errors++; $display("FAIL bp_tready: s_axis_tready low during stall=%0d, required 1", saw_low); end
        checks++;
        if (max_cnt > 2) begin errors++; $display("FAIL bp_fifo: max fifo count=%0d, required <=2", max_cnt); end
        checks++;
        if (out_n !== EXP_OUT || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL bp_count: outputs=%0d left=%0d, required %0d and 0", out_n, sb_q.size(), EXP_OUT);
        end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL bp_done: o_done pulses=%0d, required 1", done_n); end
    endtask

    task automatic test_tlast_err();
        bit to;
        frame_begin();
        err_after = 1'b0;
        run_frame(6, -1, to);
        checks++;
        if (err_before !== 1'b0) begin errors++; $display("FAIL err_before: o_err_tlast=%b at bad word, required 0", err_before); end
        checks++;
        if (err_after !== 1'b1) begin errors++; $display("FAIL err_next: o_err_tlast=%b cycle after bad word, required 1", err_after); end
        checks++;
        if (o_err_tlast !== 1'b1) begin errors++; $display("FAIL err_sticky: o_err_tlast=%b at end, required 1", o_err_tlast); end
        checks++;
        if (out_n !== EXP_OUT || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL err_count: outputs=%0d left=%0d, required %0d and 0", out_n, sb_q.size(), EXP_OUT);
        end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL err_done: o_done pulses=%0d, required 1", done_n); end
    endtask

    task automatic test_reset_mid();
        bit to;
        frame_begin();
        run_frame(-1, 8, to);
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_err_tlast, dp_valid, dp_reset, s_ready, m_valid, m_last} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_ctrl: busy/done/err/dpv/dpr/srdy/mvld/mlast=%b, required 00000000",
                     {o_busy, o_done, o_err_tlast, dp_valid, dp_reset, s_ready, m_valid, m_last});
        end
        @(posedge clk); #1;
        frame_begin();
        run_frame(-1, -1, to);
        checks++;
        if (out_n !== EXP_OUT || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_count: outputs=%0d left=%0d, required %0d and 0", out_n, sb_q.size(), EXP_OUT);
        end
        checks++;
        if (done_n !== 1 || o_err_tlast !== 1'b0) begin
            errors++;
            $display("FAIL midreset_status: done pulses=%0d err=%b, required 1 and 0", done_n, o_err_tlast);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_tlast_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
